vga_timing_ser: RTL and testbench
=================================

VGA_TIMING_SER -- requirements
Module: vga_timing_ser

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch widths in clocks.
REQ-003 SHALL have parameters V_VIS, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33: vertical visible lines, front porch, sync and back porch widths in lines.
REQ-004 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0 each: active level of each sync.
REQ-005 SHALL have parameter COLOR_W, default 8: bits per colour channel.
REQ-006 SHALL have parameter ADDR_DATA_DELAY, default 2, legal range 1..8: clocks from pixel request to pix_in being valid.
REQ-007 SHALL have parameter IDX_W, default 10: width of the pixel index outputs.
REQ-008 SHALL have parameter BLANK_COLOR, default 0, width 3*COLOR_W: colour substituted on underflow.
REQ-009 clk_pix  in  1  pixel clock; the only clock.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 en  in  1  timing enable; low holds the generator idle.
REQ-012 pix_in  in  3*COLOR_W  pixel data {b,g,r}, b in the MSBs.
REQ-013 pix_valid  in  1  pix_in holds valid data this cycle.
REQ-014 clr_underflow  in  1  clears the sticky underflow flag.
REQ-015 req_valid, req_hidx, req_vidx  out  1, IDX_W, IDX_W  pixel fetch request and its screen coordinates.
REQ-016 r_out, g_out, b_out  out  COLOR_W each  colour channels; hsync, vsync  out  1 each; de  out  1  visible-pixel flag.
REQ-017 frame_start  out  1  one-cycle pulse; underflow  out  1  sticky flag.

Function
REQ-018 Line order SHALL be sync, back porch, visible, front porch (H_TOTAL = sum of the four horizontal widths); frame order SHALL be the same in lines (V_TOTAL likewise).
REQ-019 Internal h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment on each h wrap and wrap to 0 after V_TOTAL-1.
REQ-020 hsync, vsync and de SHALL be registered and reflect counter state with a latency of exactly 1 clock; hsync is active while h_cnt<H_SYNC, and vsync is active while v_cnt<V_SYNC.
REQ-021 req_valid SHALL be asserted (registered) for the H_VIS consecutive cycles that precede, by ADDR_DATA_DELAY+1 clocks, the cycles in which de is high; it SHALL never be asserted on non-visible lines.
REQ-022 If req_valid is high in cycle t for pixel (x,y), req_hidx SHALL be x and req_vidx SHALL be y, with x in 0..H_VIS-1 and y in 0..V_VIS-1; both indices SHALL be 0 while req_valid is low.
REQ-023 The source SHALL present the requested pixel on pix_in in cycle t+ADDR_DATA_DELAY; the block SHALL show it on r/g/b_out with de=1 in cycle t+ADDR_DATA_DELAY+1.
REQ-024 rgb outputs SHALL be 0 whenever de=0.
REQ-025 If pix_valid=0 at a sampling cycle, the block SHALL output BLANK_COLOR for that pixel and set underflow=1 on the following cycle.
REQ-026 underflow SHALL be sticky until clr_underflow=1; if clr_underflow and a new underflow occur in the same cycle, set SHALL win.
REQ-027 frame_start SHALL pulse for 1 clock, coincident with the first de=1 cycle of each frame.
REQ-028 While en=0, counters SHALL hold at 0 and all outputs SHALL hold their reset values.
REQ-029 When en falls mid-frame, outputs SHALL reach reset values on the next cycle and any in-flight requests SHALL be discarded; when en rises, timing SHALL restart at h_cnt=v_cnt=0.

Reset
REQ-030 With rst=1 at a clock edge, h_cnt, v_cnt, the pipeline registers, req_valid, the indices, de, rgb, frame_start and underflow SHALL become 0, and hsync/vsync SHALL go to their inactive levels.
REQ-031 rst SHALL take priority over en and clr_underflow; the first cycle after reset deassertion with en=1 SHALL have h_cnt=0, so the active hsync appears 1 clock later.

Configuration
REQ-032 With macro VGA_SER_TEST_PATTERN_EN defined, the block SHALL add input test_mode (1 bit); while test_mode=1, visible pixels SHALL be 8 vertical bars of width H_VIS/8 with colours white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or 0; in this mode pix_in and pix_valid SHALL be ignored and underflow SHALL NOT set.
REQ-033 Without the macro, the block SHALL have no test_mode port and no pattern logic.

Verification
REQ-034 Defaults, en=1, after reset: the hsync period SHALL be 800 clocks with 96 clocks low; the vsync period SHALL be 420000 clocks with 1600 clocks low; de SHALL be high for 640x480 per frame.
REQ-035 With pix_in driven as {0,vidx,hidx}[23:0] using ADDR_DATA_DELAY=2, pixel (5,7) SHALL appear with r_out=5, g_out=7, exactly 3 clocks after its request.
REQ-036 pix_valid=0 for one sampling cycle: that pixel SHALL be BLANK_COLOR and underflow SHALL rise 1 clock later and stay high; clr_underflow pulsed SHALL clear it; clr plus a simultaneous new underflow SHALL leave underflow=1.
REQ-037 en dropped at line 100: outputs SHALL be idle the next cycle; after en is raised, frame_start SHALL occur 35*800+144 clocks later.
REQ-038 With HSYNC_POL=1, H_VIS=16, H_FP=2, H_SYNC=3, H_BP=1, V_VIS=4, V_FP=V_SYNC=V_BP=1: the line SHALL be 22 clocks with hsync high for 3 clocks; the index wrap SHALL be correct.
REQ-039 With VGA_SER_TEST_PATTERN_EN and test_mode=1: pixel 80 SHALL be yellow (r=g=255, b=0) and pixel 639 SHALL be black.

Source files
------------

// File: rtl/vga_timing_ser.sv
// vga_timing_ser: VGA raster timing generator with a pixel-fetch request
// pipeline. Requests lead the visible window by ADDR_DATA_DELAY+1 clocks so
// the returned pixel lands exactly on the matching de=1 cycle.
// Optional feature: define VGA_SER_TEST_PATTERN_EN to add the test_mode input
// (8 vertical colour bars, pixel source and underflow detection bypassed).
module vga_timing_ser #(
   parameter int                     H_VIS           = 640,
   parameter int                     H_FP            = 16,
   parameter int                     H_SYNC          = 96,
   parameter int                     H_BP            = 48,
   parameter int                     V_VIS           = 480,
   parameter int                     V_FP            = 10,
   parameter int                     V_SYNC          = 2,
   parameter int                     V_BP            = 33,
   parameter logic                   HSYNC_POL       = 1'b0,
   parameter logic                   VSYNC_POL       = 1'b0,
   parameter int                     COLOR_W         = 8,
   parameter int                     ADDR_DATA_DELAY = 2,
   parameter int                     IDX_W           = 10,
   parameter logic [3*COLOR_W-1:0]   BLANK_COLOR     = '0
) (
   input  logic                   clk_pix,
   input  logic                   rst,
   input  logic                   en,
   input  logic [3*COLOR_W-1:0]   pix_in,
   input  logic                   pix_valid,
   input  logic                   clr_underflow,
`ifdef VGA_SER_TEST_PATTERN_EN
   input  logic                   test_mode,
`endif
   output logic                   req_valid,
   output logic [IDX_W-1:0]       req_hidx,
   output logic [IDX_W-1:0]       req_vidx,
   output logic [COLOR_W-1:0]     r_out,
   output logic [COLOR_W-1:0]     g_out,
   output logic [COLOR_W-1:0]     b_out,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   de,
   output logic                   frame_start,
   output logic                   underflow
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
   localparam int HC_W    = $clog2(H_TOTAL + 1);
   localparam int VC_W    = $clog2(V_TOTAL + 1);
   localparam int D       = ADDR_DATA_DELAY;

   localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] HS_END = HC_W'(H_SYNC);
   localparam logic [HC_W-1:0] HA_S   = HC_W'(H_SYNC + H_BP);
   localparam logic [HC_W-1:0] HA_E   = HC_W'(H_SYNC + H_BP + H_VIS);
   // Request window is the visible window shifted D+1 clocks earlier within
   // the same line; this relies on H_SYNC+H_BP >= ADDR_DATA_DELAY+1.
   localparam logic [HC_W-1:0] RQ_S   = HC_W'(H_SYNC + H_BP - D - 1);
   localparam logic [HC_W-1:0] RQ_E   = HC_W'(H_SYNC + H_BP - D - 1 + H_VIS);
   localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] VS_END = VC_W'(V_SYNC);
   localparam logic [VC_W-1:0] VA_S   = VC_W'(V_SYNC + V_BP);
   localparam logic [VC_W-1:0] VA_E   = VC_W'(V_SYNC + V_BP + V_VIS);

   logic [HC_W-1:0]        h_cnt_q, h_cnt_d;
   logic [VC_W-1:0]        v_cnt_q, v_cnt_d;
   logic                   h_vis, v_vis, rq_win;
   logic                   req_valid_q;
   logic [IDX_W-1:0]       req_hidx_q, req_vidx_q;
   logic [D-1:0]           samp_q;
   logic                   samp;
   logic [3*COLOR_W-1:0]   rgb_q;
   logic                   hsync_q, vsync_q, de_q, frame_start_q, underflow_q;
   logic [3*COLOR_W-1:0]   pix_src;
   logic                   pix_ok;

   // Counter next-state and raster window decode
   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
      h_vis  = (h_cnt_q >= HA_S) && (h_cnt_q < HA_E);
      v_vis  = (v_cnt_q >= VA_S) && (v_cnt_q < VA_E);
      rq_win = (h_cnt_q >= RQ_S) && (h_cnt_q < RQ_E) && v_vis;
   end

   // The sample cycle is the last stage of the request delay line
   assign samp = samp_q[D-1];

`ifdef VGA_SER_TEST_PATTERN_EN
   localparam int              BAR_W   = (H_VIS >= 8) ? H_VIS / 8 : 1;
   localparam logic [HC_W-1:0] BAR_W_C = HC_W'(BAR_W);
   localparam logic [HC_W-1:0] BAR_7_C = HC_W'(7 * BAR_W);
   logic [HC_W-1:0] tp_x;
   logic [2:0]      tp_bar, tp_bgr;

   // Pixel source: colour bars indexed by the column being sampled, or pix_in
   always_comb begin
      tp_x = h_cnt_q - HA_S;
      if (tp_x >= BAR_7_C) tp_bar = 3'd7;
      else                 tp_bar = 3'(tp_x / BAR_W_C);
      case (tp_bar)
         3'd0:    tp_bgr = 3'b111;  // white
         3'd1:    tp_bgr = 3'b011;  // yellow
         3'd2:    tp_bgr = 3'b110;  // cyan
         3'd3:    tp_bgr = 3'b010;  // green
         3'd4:    tp_bgr = 3'b101;  // magenta
         3'd5:    tp_bgr = 3'b001;  // red
         3'd6:    tp_bgr = 3'b100;  // blue
         default: tp_bgr = 3'b000;  // black
      endcase
      pix_src = pix_in;
      pix_ok  = pix_valid;
      if (test_mode) begin
         pix_src = {{COLOR_W{tp_bgr[2]}}, {COLOR_W{tp_bgr[1]}}, {COLOR_W{tp_bgr[0]}}};
         pix_ok  = 1'b1;
      end
   end
`else
   // Pixel source: external fetch data only
   always_comb begin
      pix_src = pix_in;
      pix_ok  = pix_valid;
   end
`endif

   // Counters, request pipeline and registered outputs; en=0 idles like reset
   always_ff @(posedge clk_pix) begin
      if (rst || !en) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         req_valid_q   <= 1'b0;
         req_hidx_q    <= '0;
         req_vidx_q    <= '0;
         samp_q        <= '0;
         rgb_q         <= '0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         de_q          <= 1'b0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         req_valid_q   <= rq_win;
         req_hidx_q    <= rq_win ? IDX_W'(h_cnt_q - RQ_S) : '0;
         req_vidx_q    <= rq_win ? IDX_W'(v_cnt_q - VA_S) : '0;
         samp_q        <= D'({samp_q, req_valid_q});
         rgb_q         <= samp ? (pix_ok ? pix_src : BLANK_COLOR) : '0;
         hsync_q       <= (h_cnt_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
         vsync_q       <= (v_cnt_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
         de_q          <= h_vis && v_vis;
         frame_start_q <= (h_cnt_q == HA_S) && (v_cnt_q == VA_S);
         // a new underflow outranks a simultaneous clear
         underflow_q   <= (samp && !pix_ok) || (underflow_q && !clr_underflow);
      end
   end

   assign req_valid   = req_valid_q;
   assign req_hidx    = req_hidx_q;
   assign req_vidx    = req_vidx_q;
   assign r_out       = rgb_q[COLOR_W-1:0];
   assign g_out       = rgb_q[2*COLOR_W-1:COLOR_W];
   assign b_out       = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_ser.sv
// tb_vga_timing_ser: directed bench for vga_timing_ser. Instance A uses the
// default 640x480 timing, instance B a tiny 16x4 raster with active-high hsync
// and a non-zero blank colour. A behavioural fetch source answers requests
// ADDR_DATA_DELAY=2 clocks later with {0, vidx, hidx}.
module tb_vga_timing_ser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en_a, en_b, clr_a, clr_b, pv_a, pv_b;
   logic [23:0] pin_a, pin_b;
   logic        rv_a, rv_b;
   logic [9:0]  rh_a, rvv_a, rh_b, rvv_b;
   logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        hs_a, vs_a, de_a, fs_a, uf_a;
   logic        hs_b, vs_b, de_b, fs_b, uf_b;
`ifdef VGA_SER_TEST_PATTERN_EN
   logic        tm = 1'b0;
`endif

   vga_timing_ser #(.ADDR_DATA_DELAY(2)) dut_a (
      .clk_pix(clk), .rst(rst), .en(en_a), .pix_in(pin_a), .pix_valid(pv_a),
      .clr_underflow(clr_a),
`ifdef VGA_SER_TEST_PATTERN_EN
      .test_mode(tm),
`endif
      .req_valid(rv_a), .req_hidx(rh_a), .req_vidx(rvv_a),
      .r_out(r_a), .g_out(g_a), .b_out(b_a), .hsync(hs_a), .vsync(vs_a),
      .de(de_a), .frame_start(fs_a), .underflow(uf_a));

   vga_timing_ser #(
      .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .ADDR_DATA_DELAY(2), .BLANK_COLOR(24'h123456)) dut_b (
      .clk_pix(clk), .rst(rst), .en(en_b), .pix_in(pin_b), .pix_valid(pv_b),
      .clr_underflow(clr_b),
`ifdef VGA_SER_TEST_PATTERN_EN
      .test_mode(tm),
`endif
      .req_valid(rv_b), .req_hidx(rh_b), .req_vidx(rvv_b),
      .r_out(r_b), .g_out(g_b), .b_out(b_b), .hsync(hs_b), .vsync(vs_b),
      .de(de_b), .frame_start(fs_b), .underflow(uf_b));

   int   checks = 0;
   int   errors = 0;
   int   cyc;
   logic hva [0:7];
   logic hvb [0:7];
   int   hxa [0:7];
   int   hya [0:7];
   int   hxb [0:7];
   int   hyb [0:7];
   logic drop_en;
   int   drop_x, drop_y;
   int   a_hs_low = 0;
   int   a_fs_cyc = -1;
   logic a_hs96, a_hs800;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // one clock: step past the edge, record requests, answer the ones 2 clocks old
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 7; k > 0; k--) begin
         hva[k] = hva[k-1]; hxa[k] = hxa[k-1]; hya[k] = hya[k-1];
         hvb[k] = hvb[k-1]; hxb[k] = hxb[k-1]; hyb[k] = hyb[k-1];
      end
      hva[0] = rv_a; hxa[0] = int'(rh_a); hya[0] = int'(rvv_a);
      hvb[0] = rv_b; hxb[0] = int'(rh_b); hyb[0] = int'(rvv_b);
      pin_a = hva[2] ? {8'h00, 8'(hya[2]), 8'(hxa[2])} : 24'h0;
      pv_a  = hva[2];
      pin_b = hvb[2] ? {8'h00, 8'(hyb[2]), 8'(hxb[2])} : 24'h0;
      pv_b  = hvb[2] && !(drop_en && hxb[2] == drop_x && hyb[2] == drop_y);
      if (cyc >= 0 && cyc < 800 && !hs_a) a_hs_low++;
      if (cyc == 96)  a_hs96  = hs_a;
      if (cyc == 800) a_hs800 = hs_a;
      if (cyc >= 0 && fs_a && a_fs_cyc < 0) a_fs_cyc = cyc;
   endtask

   initial begin
      int   b_hs_hi, b_vs_act, b_de, b_rq, b_fs_cyc;
      int   bad_idx, bad_rgb, bad_lat, ex, ey, ox, oy, n;
      logic b_hs22;
      b_hs_hi = 0; b_vs_act = 0; b_de = 0; b_rq = 0; b_fs_cyc = -1;
      bad_idx = 0; bad_rgb = 0; bad_lat = 0; ex = 0; ey = 0; ox = 0; oy = 0;
      b_hs22 = 1'b0; n = 0;
      for (int k = 0; k < 8; k++) begin
         hva[k] = 1'b0; hxa[k] = 0; hya[k] = 0;
         hvb[k] = 1'b0; hxb[k] = 0; hyb[k] = 0;
      end
      rst = 1'b1; en_a = 1'b1; en_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
      pv_a = 1'b0; pv_b = 1'b0; pin_a = '0; pin_b = '0;
      drop_en = 1'b0; drop_x = 0; drop_y = 0; a_hs96 = 1'b0; a_hs800 = 1'b1;
      cyc = -100;
      repeat (3) tick();

      // reset state: syncs inactive, everything else zero
      chk("a_rst_ctl", {hs_a, vs_a, de_a, fs_a, uf_a, rv_a}, 32'b110000);
      chk("a_rst_idx", {rh_a, rvv_a}, 32'h0);
      chk("a_rst_rgb", {b_a, g_a, r_a}, 32'h0);
      chk("b_rst_ctl", {hs_b, vs_b, de_b, fs_b, uf_b, rv_b}, 32'b010000);
      chk("b_rst_rgb", {b_b, g_b, r_b, rh_b, rvv_b}, 32'h0);

      // first edge after release has h_cnt=0, so sync is active right after it
      rst = 1'b0;
      cyc = -1;
      tick();
      chk("a_hs_first", hs_a, 0);
      chk("b_hs_first", hs_b, 1);

      // B: one full 22x7 frame of statistics and data/index ordering
      for (int i = 0; i < 154; i++) begin
         if (i < 22 && hs_b) b_hs_hi++;
         if (i == 22) b_hs22 = hs_b;
         if (!vs_b) b_vs_act++;
         if (fs_b && b_fs_cyc < 0) b_fs_cyc = i;
         if (rv_b) begin
            b_rq++;
            if (int'(rh_b) != ex || int'(rvv_b) != ey) bad_idx++;
            ex++;
            if (ex == 16) begin ex = 0; ey++; end
         end else if (rh_b != 10'd0 || rvv_b != 10'd0) begin
            bad_idx++;
         end
         if (de_b) begin
            b_de++;
            if (r_b != 8'(ox) || g_b != 8'(oy) || b_b != 8'd0) bad_rgb++;
            ox++;
            if (ox == 16) begin ox = 0; oy++; end
         end else if ({b_b, g_b, r_b} != 24'h0) begin
            bad_rgb++;
         end
         if (de_b !== hvb[3]) bad_lat++;
         tick();
      end
      chk("b_hs_width", b_hs_hi, 3);
      chk("b_hs_period", b_hs22, 1);
      chk("b_vs_width", b_vs_act, 22);
      chk("b_de_count", b_de, 64);
      chk("b_req_count", b_rq, 64);
      chk("b_req_rows", ey, 4);
      chk("b_fs_cycle", b_fs_cyc, 48);
      chk("b_idx_seq", bad_idx, 0);
      chk("b_rgb_seq", bad_rgb, 0);
      chk("b_req_to_de", bad_lat, 0);
      chk("b_uf_clean", uf_b, 0);

      // B: pixel (5,1) of frame 2 requested at 226, sampled at 228 with no data
      drop_en = 1'b1; drop_x = 5; drop_y = 1;
      while (cyc < 228) tick();
      chk("b_uf_before", uf_b, 0);
      tick();
      chk("b_blank_rgb", {b_b, g_b, r_b}, 32'h123456);
      chk("b_blank_de", de_b, 1);
      chk("b_uf_set", uf_b, 1);
      tick();
      chk("b_after_blank", {b_b, g_b, r_b}, 32'h000106);
      while (cyc < 240) tick();
      chk("b_uf_sticky", uf_b, 1);
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      chk("b_uf_clr", uf_b, 0);
      // pixel (10,2): requested at 253, sampled at 255 together with a clear
      drop_x = 10; drop_y = 2;
      while (cyc < 255) tick();
      chk("b_uf_pre2", uf_b, 0);
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      chk("b_uf_set_wins", uf_b, 1);
      drop_en = 1'b0;
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      chk("b_uf_clr2", uf_b, 0);

      // B: drop en mid visible line 3 of frame 3, then restart from 0,0
      while (cyc < 382) tick();
      chk("b_de_pre_drop", de_b, 1);
      en_b = 1'b0;
      tick();
      chk("b_idle_ctl", {hs_b, vs_b, de_b, fs_b, uf_b, rv_b}, 32'b010000);
      chk("b_idle_data", {b_b, g_b, r_b, rh_b, rvv_b}, 32'h0);
      repeat (4) tick();
      chk("b_idle_hold", {hs_b, vs_b, de_b, rv_b, b_b, g_b, r_b}, 32'b0100 << 24);
      en_b = 1'b1;
      tick();
      chk("b_restart_hs", hs_b, 1);
      while (!fs_b && n < 200) begin
         tick();
         n++;
      end
      chk("b_restart_fs", n, 48);
      chk("b_restart_de", de_b, 1);
      tick();
      chk("b_restart_px1", {b_b, g_b, r_b}, 32'h000001);

      // A: pixel (5,7) requested at edge 42*800+146, shown 3 clocks later
      while (cyc < 33746) tick();
      chk("a_req_valid", rv_a, 1);
      chk("a_req_idx", {rh_a, rvv_a}, {12'h0, 10'd5, 10'd7});
      repeat (3) tick();
      chk("a_px_de", de_a, 1);
      chk("a_px_rgb", {b_a, g_a, r_a}, 32'h000705);
      chk("a_hs_low", a_hs_low, 96);
      chk("a_hs_96", a_hs96, 1);
      chk("a_hs_800", a_hs800, 0);
      chk("a_fs_cycle", a_fs_cyc, 28144);
      chk("a_uf_clean", uf_a, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
